// File: rtl/dcache_outq_mp.sv
// Multi-port dcache output queue: circular buffer of completed dcache responses.
// Up to DEQ_WIDTH oldest entries are presented to the ROB, which retires an in-order prefix.
module dcache_outq_mp #(
  parameter int Q_LENGTH     = 8,
  parameter int DATA_SIZE    = 32,
  parameter int OOO_TAG_SIZE = 10,
  parameter int OOO_ROB_SIZE = 10,
  parameter int DEQ_WIDTH    = 2,
  parameter int AF_THRESH    = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [31:0]                        addr_in,
  input  logic [DATA_SIZE-1:0]               data_in,
  input  logic [2:0]                         operation_in,
  input  logic                               is_flush_in,
  input  logic [OOO_TAG_SIZE-1:0]            tag_in,
  input  logic [OOO_ROB_SIZE-1:0]            rob_line_in,
  input  logic                               alloc,
  input  logic [DEQ_WIDTH-1:0]               dealloc,
  input  logic                               resteer,
  output logic                               full,
  output logic                               almost_full,
  output logic [$clog2(Q_LENGTH+1)-1:0]      count,
  output logic                               ovf_err,
  output logic [DEQ_WIDTH*32-1:0]            addr_out,
  output logic [DEQ_WIDTH*DATA_SIZE-1:0]     data_out,
  output logic [DEQ_WIDTH-1:0]               is_st_out,
  output logic [DEQ_WIDTH-1:0]               is_flush_out,
  output logic [DEQ_WIDTH*OOO_TAG_SIZE-1:0]  tag_out,
  output logic [DEQ_WIDTH*OOO_ROB_SIZE-1:0]  rob_line_out,
  output logic [DEQ_WIDTH-1:0]               valid_out
);

  localparam int PTR_W = $clog2(Q_LENGTH);
  localparam int CNT_W = $clog2(Q_LENGTH + 1);
  localparam logic [2:0] OP_ST = 3'd2;

  logic [31:0]             mem_addr_q  [Q_LENGTH];
  logic [DATA_SIZE-1:0]    mem_data_q  [Q_LENGTH];
  logic [2:0]              mem_op_q    [Q_LENGTH];
  logic                    mem_flush_q [Q_LENGTH];
  logic [OOO_TAG_SIZE-1:0] mem_tag_q   [Q_LENGTH];
  logic [OOO_ROB_SIZE-1:0] mem_rob_q   [Q_LENGTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             enq;
  logic             run;
  logic [CNT_W-1:0] n_ret;
  logic [PTR_W-1:0] rd_idx;

  assign full        = (count_q == CNT_W'(Q_LENGTH));
  assign almost_full = (count_q >= CNT_W'(AF_THRESH));
  assign count       = count_q;
  assign ovf_err     = ovf_q;
  assign enq         = alloc & ~full & ~resteer;

  always_comb begin
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      valid_out[i] = (count_q > CNT_W'(i)) & ~resteer;
    end
  end

  // Retire stops at the first slot that is not both requested and valid.
  always_comb begin
    n_ret = '0;
    run   = 1'b1;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      if (run && dealloc[i] && valid_out[i]) begin
        n_ret = n_ret + CNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  always_comb begin
    addr_out     = '0;
    data_out     = '0;
    is_st_out    = '0;
    is_flush_out = '0;
    tag_out      = '0;
    rob_line_out = '0;
    rd_idx       = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      rd_idx                                   = head_q + PTR_W'(i);
      addr_out[i*32 +: 32]                     = mem_addr_q[rd_idx];
      data_out[i*DATA_SIZE +: DATA_SIZE]       = mem_data_q[rd_idx];
      is_st_out[i]                             = (mem_op_q[rd_idx] == OP_ST);
      is_flush_out[i]                          = mem_flush_q[rd_idx];
      tag_out[i*OOO_TAG_SIZE +: OOO_TAG_SIZE]  = mem_tag_q[rd_idx];
      rob_line_out[i*OOO_ROB_SIZE +: OOO_ROB_SIZE] = mem_rob_q[rd_idx];
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(n_ret);
    tail_d  = tail_q + PTR_W'(enq);
    count_d = count_q + CNT_W'(enq) - n_ret;
    ovf_d   = ovf_q | (alloc & full & ~resteer);
    if (resteer) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Payload RAM needs no reset; entries are only read while their slot is valid.
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      mem_addr_q[tail_q]  <= addr_in;
      mem_data_q[tail_q]  <= data_in;
      mem_op_q[tail_q]    <= operation_in;
      mem_flush_q[tail_q] <= is_flush_in;
      mem_tag_q[tail_q]   <= tag_in;
      mem_rob_q[tail_q]   <= rob_line_in;
    end
  end

endmodule

// File: tb/tb_dcache_outq_mp.sv
// Directed bench for dcache_outq_mp with hand-computed expectations.
module tb_dcache_outq_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_in = '0;
  logic [31:0] data_in = '0;
  logic [2:0]  operation_in = '0;
  logic        is_flush_in = 1'b0;
  logic [9:0]  tag_in = '0;
  logic [9:0]  rob_line_in = '0;
  logic        alloc = 1'b0;
  logic [1:0]  dealloc = '0;
  logic        resteer = 1'b0;
  logic        full, almost_full, ovf_err;
  logic [3:0]  count;
  logic [63:0] addr_out, data_out;
  logic [1:0]  is_st_out, is_flush_out, valid_out;
  logic [19:0] tag_out, rob_line_out;

  int n_chk = 0;
  int n_pass = 0;

  dcache_outq_mp dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
    .operation_in(operation_in), .is_flush_in(is_flush_in), .tag_in(tag_in),
    .rob_line_in(rob_line_in), .alloc(alloc), .dealloc(dealloc), .resteer(resteer),
    .full(full), .almost_full(almost_full), .count(count), .ovf_err(ovf_err),
    .addr_out(addr_out), .data_out(data_out), .is_st_out(is_st_out),
    .is_flush_out(is_flush_out), .tag_out(tag_out), .rob_line_out(rob_line_out),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [2:0] op, input logic [9:0] t);
    addr_in      = a;
    data_in      = a ^ 32'hA5A5_0000;
    operation_in = op;
    tag_in       = t;
    rob_line_in  = t + 10'd1;
  endtask

  // Structural invariants: bounded occupancy and tail = head + count.
  always @(negedge clk) begin
    logic [2:0] tail_exp;
    if (!rst) begin
      tail_exp = dut.head_q + 3'(dut.count_q);
      chk("inv_cnt_le_q", 64'(dut.count_q <= 4'd8), 64'd1);
      chk("inv_tail", 64'(dut.tail_q), 64'(tail_exp));
    end
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_af", 64'(almost_full), 64'd0);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_ovf", 64'(ovf_err), 64'd0);

    // three enqueues: LD, ST, LD
    for (int i = 0; i < 3; i++) begin
      drive(32'h100 + 32'(4 * i), (i == 1) ? 3'd2 : 3'd1, 10'(i));
      alloc = 1'b1;
      tick();
    end
    alloc = 1'b0;
    chk("enq3_count", 64'(count), 64'd3);
    chk("enq3_valid", 64'(valid_out), 64'h3);
    chk("enq3_addr0", 64'(addr_out[31:0]), 64'h100);
    chk("enq3_addr1", 64'(addr_out[63:32]), 64'h104);
    chk("enq3_is_st", 64'(is_st_out), 64'h2);
    chk("enq3_data0", 64'(data_out[31:0]), 64'hA5A5_0100);
    chk("enq3_tag1", 64'(tag_out[19:10]), 64'd1);
    chk("enq3_rob0", 64'(rob_line_out[9:0]), 64'd1);

    dealloc = 2'b11;
    tick();
    chk("ret2_count", 64'(count), 64'd1);
    chk("ret2_addr0", 64'(addr_out[31:0]), 64'h108);
    chk("ret2_valid", 64'(valid_out), 64'h1);
    dealloc = 2'b10;
    tick();
    chk("gap_count", 64'(count), 64'd1);
    chk("gap_addr0", 64'(addr_out[31:0]), 64'h108);
    dealloc = 2'b11;
    tick();
    dealloc = 2'b00;
    chk("ret_partial_count", 64'(count), 64'd0);
    chk("ret_partial_valid", 64'(valid_out), 64'h0);

    // fill to capacity
    for (int i = 0; i < 8; i++) begin
      drive(32'h200 + 32'(4 * i), 3'd1, 10'(i));
      alloc = 1'b1;
      tick();
      chk("fill_af", 64'(almost_full), 64'(i + 1 >= 6));
      chk("fill_full", 64'(full), 64'(i + 1 == 8));
    end
    drive(32'hDEAD, 3'd2, 10'd99);
    tick();
    chk("ovf_set", 64'(ovf_err), 64'd1);
    chk("ovf_count", 64'(count), 64'd8);
    dealloc = 2'b01;
    tick();
    chk("full_alloc_ret_count", 64'(count), 64'd7);
    chk("full_alloc_ret_addr0", 64'(addr_out[31:0]), 64'h204);
    chk("ovf_sticky", 64'(ovf_err), 64'd1);

    // steady alloc+retire across pointer wrap
    for (int k = 0; k < 20; k++) begin
      drive(32'h220 + 32'(4 * k), 3'd1, 10'(k));
      tick();
      chk("wrap_count", 64'(count), 64'd7);
      chk("wrap_addr0", 64'(addr_out[31:0]), 64'(32'h208 + 32'(4 * k)));
      chk("wrap_addr1", 64'(addr_out[63:32]), 64'(32'h20C + 32'(4 * k)));
    end
    alloc = 1'b0;
    dealloc = 2'b11;
    tick();
    chk("pre_rs_count", 64'(count), 64'd5);

    // resteer with simultaneous alloc and dealloc
    drive(32'hBEEF, 3'd1, 10'd5);
    resteer = 1'b1;
    alloc   = 1'b1;
    dealloc = 2'b11;
    #1;
    chk("rs_valid", 64'(valid_out), 64'h0);
    tick();
    resteer = 1'b0;
    alloc   = 1'b0;
    dealloc = 2'b00;
    chk("rs_count", 64'(count), 64'd0);
    chk("rs_full", 64'(full), 64'd0);
    chk("rs_ovf_kept", 64'(ovf_err), 64'd1);
    drive(32'h300, 3'd2, 10'd7);
    alloc = 1'b1;
    tick();
    chk("post_rs_count", 64'(count), 64'd1);
    chk("post_rs_addr0", 64'(addr_out[31:0]), 64'h300);

    // build to 4 entries then reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(32'h304 + 32'(4 * i), 3'd1, 10'(i));
      tick();
    end
    alloc = 1'b0;
    chk("pre_rst_count", 64'(count), 64'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_ovf", 64'(ovf_err), 64'd0);
    chk("mid_rst_valid", 64'(valid_out), 64'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
